mem_responder_m: RTL and testbench

Word-addressed data-memory responder for the multi-cycle MIPS core. It is the target end of the core's memory request interface. It accepts one read or write request at a time over a valid/ready handshake and services it from an internal word array after a fixed, parameterised number of wait cycles. It then holds a registered response until the core takes it. It replaces the zero-latency memory model so the core's memory-wait states can be exercised.

---
 rtl/mem_responder_m_if.sv | 26 ++
 rtl/mem_responder_m.sv | 112 +++++++++++
 tb/tb_mem_responder_m.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_m_if.sv
// Memory request/response bus between the core (master) and a memory responder (slave).
interface mem_responder_m_if #(
  parameter int WIDTH = 5
);
  localparam int DW = 2 ** WIDTH;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder_m.sv
// Word-addressed data memory answering one request at a time after LATENCY wait cycles.
//   state | meaning
//   IDLE  | ready for a request; captures it on acceptance
//   WAIT  | counting down wait cycles; commits when counter reaches 0
//   RESP  | holding registered response until resp_ready
module mem_responder_m #(
  parameter int WIDTH      = 5,
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input logic              clk,
  input logic              rst,
  mem_responder_m_if.slave bus
);
  localparam int DW    = 2 ** WIDTH;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          ready_q;
  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          resp_valid_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic [DW-1:0] mem [DEPTH];

  logic                  commit_en;
  logic                  c_we;
  logic [DW-1:0]         c_addr;
  logic [DW-1:0]         c_wdata;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;

  // With zero latency the commit uses the live request on the acceptance edge.
  always_comb begin
    commit_en = 1'b0;
    c_we      = we_q;
    c_addr    = addr_q;
    c_wdata   = wdata_q;
    if (state == IDLE && bus.req_valid && LATENCY == 0) begin
      commit_en = 1'b1;
      c_we      = bus.req_we;
      c_addr    = bus.req_addr;
      c_wdata   = bus.req_wdata;
    end else if (state == WAIT && cnt == 4'd0) begin
      commit_en = 1'b1;
    end
  end

  assign c_err = (c_addr[1:0] != 2'b00) || (|c_addr[DW-1:DEPTH_LOG2+2]);
  assign c_idx = c_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt     <= CNT_INIT;
            ready_q <= 1'b0;
            state   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
      if (commit_en) begin
        resp_valid_q <= 1'b1;
        err_q        <= c_err;
        rdata_q      <= (c_err || c_we) ? '0 : mem[c_idx];
      end
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit_en && c_we && !c_err) mem[c_idx] <= c_wdata;
  end

  assign bus.req_ready  = ready_q & rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder_m.sv
// Scoreboard bench for mem_responder_m: a LATENCY=2 and a LATENCY=0 instance share one driver and monitor.
module tb_mem_responder_m;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  int          cyc = 0;
  int          ncmp = 0;
  int          nmis = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  logic [31:0] mm [2][64];

  mem_responder_m_if #(.WIDTH(5)) b2 ();
  mem_responder_m_if #(.WIDTH(5)) b0 ();

  mem_responder_m #(.WIDTH(5), .DEPTH_LOG2(6), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  mem_responder_m #(.WIDTH(5), .DEPTH_LOG2(6), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  assign b2.req_valid  = req_valid & ~sel;
  assign b2.req_we     = req_we;
  assign b2.req_addr   = req_addr;
  assign b2.req_wdata  = req_wdata;
  assign b2.resp_ready = resp_ready & ~sel;
  assign b0.req_valid  = req_valid & sel;
  assign b0.req_we     = req_we;
  assign b0.req_addr   = req_addr;
  assign b0.req_wdata  = req_wdata;
  assign b0.resp_ready = resp_ready & sel;

  logic        cur_req_ready, cur_resp_valid, cur_resp_ready, cur_err;
  logic [31:0] cur_rdata;
  assign cur_req_ready  = sel ? b0.req_ready  : b2.req_ready;
  assign cur_resp_valid = sel ? b0.resp_valid : b2.resp_valid;
  assign cur_resp_ready = sel ? b0.resp_ready : b2.resp_ready;
  assign cur_rdata      = sel ? b0.resp_rdata : b2.resp_rdata;
  assign cur_err        = sel ? b0.resp_err   : b2.resp_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency, stability and backpressure while valid; payload at handshake.
  logic        mon_prev = 1'b0;
  logic [31:0] hold_rd;
  logic        hold_err;
  always @(negedge clk) begin
    if (!rst) begin
      mon_prev = 1'b0;
    end else begin
      if (cur_resp_valid) begin
        chk("ready_low_in_resp", cur_req_ready, 0);
        if (!mon_prev) begin
          if (q.size() == 0) chk("unexpected_resp", q.size(), 1);
          else chk("latency", cyc - q[0].acc, q[0].lat);
          hold_rd  = cur_rdata;
          hold_err = cur_err;
        end else begin
          chk("rdata_stable", cur_rdata, hold_rd);
          chk("err_stable", cur_err, hold_err);
        end
        if (cur_resp_ready && q.size() > 0) begin
          chk("rdata", cur_rdata, q[0].rd);
          chk("err", cur_err, q[0].err);
          void'(q.pop_front());
        end
      end
      mon_prev = cur_resp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: 64-word array; misaligned or >= 256 is an error, no write, rdata 0.
  task automatic txn(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input bit intrude);
    exp_t e;
    int   n;
    logic [5:0] idx;
    sel = s; req_we = we; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1; resp_ready = (hold == 0);
    n = 0;
    while (!cur_req_ready && n < 100) begin step(); n++; end
    if (!cur_req_ready) begin
      chk("accept_timeout", cur_req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    idx   = addr[7:2];
    e.err = (addr[1:0] != 2'b00) || (addr >= 32'd256);
    e.rd  = 32'h0;
    if (!e.err) begin
      if (we) mm[s][idx] = wd;
      else    e.rd = mm[s][idx];
    end
    e.acc = cyc + 1;
    e.lat = s ? 0 : 2;
    q.push_back(e);
    step();
    req_valid = 1'b0;
    if (intrude) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
    end
    n = 0;
    while (!cur_resp_valid && n < 40) begin step(); n++; end
    if (!cur_resp_valid) chk("resp_timeout", cur_resp_valid, 1);
    repeat (hold) step();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    while (cur_resp_valid && n < 40) begin step(); n++; end
    if (cur_resp_valid) chk("handshake_timeout", cur_resp_valid, 0);
    resp_ready = 1'b0;
  endtask

  // Write to the LATENCY=2 instance, then assert reset dly cycles after acceptance.
  task automatic abort_w(input logic [31:0] addr, input logic [31:0] wd, input int dly);
    int n;
    sel = 1'b0; req_we = 1'b1; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1; resp_ready = 1'b0;
    n = 0;
    while (!cur_req_ready && n < 100) begin step(); n++; end
    chk("abort_accept", cur_req_ready, 1);
    step();
    req_valid = 1'b0;
    repeat (dly) step();
    rst = 1'b0;
    step();
    chk("abort_resp_valid", b2.resp_valid, 0);
    chk("abort_req_ready", b2.req_ready, 0);
    chk("abort_err", b2.resp_err, 0);
    step();
    rst = 1'b1;
    step();
    chk("abort_idle_ready", b2.req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    rst = 1'b0;
    step();
    step();
    chk("rst_resp_valid", b2.resp_valid, 0);
    chk("rst_rdata", b2.resp_rdata, 0);
    chk("rst_err", b2.resp_err, 0);
    chk("rst_req_ready", b2.req_ready, 0);
    chk("rst_req_ready0", b0.req_ready, 0);
    chk("rst_resp_valid0", b0.resp_valid, 0);
    rst = 1'b1;
    step();
    chk("release_req_ready", b2.req_ready, 1);
    chk("release_req_ready0", b0.req_ready, 1);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++)
        txn(s[0], 1'b1, 32'(i * 4), (i == 0) ? 32'h1 : (i == 8) ? 32'h0 : $urandom, 0, 1'b0);

    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h12, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h100, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b1, 32'h102, 32'h55555555, 1, 1'b0);
    txn(1'b0, 1'b0, 32'h00, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 5, 1'b1);
    txn(1'b0, 1'b0, 32'h00, 32'h0, 0, 1'b0);

    txn(1'b1, 1'b1, 32'h3C, 32'hA5A5A5A5, 0, 1'b0);
    txn(1'b1, 1'b0, 32'h3C, 32'h0, 0, 1'b0);
    txn(1'b1, 1'b0, 32'h3E, 32'h0, 2, 1'b0);

    abort_w(32'h20, 32'h12345678, 0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    abort_w(32'h20, 32'hCAFEF00D, 1);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 6)      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'd256 + 32'($urandom_range(0, 1000)) * 32'd4;
      else             a = $urandom;
      txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom,
          int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (4) step();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
